// File: rtl/mem_access_unit.sv
// Memory access unit: turns multicycle-controller access strobes into one valid/ready
// transaction on a shared I/D memory port. Optional feature macro: MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ir_write,
  input  logic                  address_source,
  input  logic                  memory_write,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] old_pc,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] KIND_FETCH = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

`ifdef MEM_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  logic [1:0]            state;
  logic [1:0]            kind;
  logic [ADDR_WIDTH-1:0] cap_pc;
  logic [CNT_W-1:0]      wait_cnt;

  logic                  req_any;
  logic [1:0]            req_kind;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_misaligned;
  logic                  timeout;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    req_any  = ir_write | address_source;
    req_addr = alu_result;
    req_kind = KIND_LOAD;
    if (ir_write) begin
      req_addr = pc;
      req_kind = KIND_FETCH;
    end else if (memory_write) begin
      req_kind = KIND_STORE;
    end
    req_misaligned = (req_addr[1:0] != 2'b00);
  end

  // Wait counter only ever advances when the timeout feature is compiled in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (TIMEOUT_EN && (state == ST_ACCESS)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout = TIMEOUT_EN && (state == ST_ACCESS) && !mem_ready &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      kind      <= KIND_FETCH;
      cap_pc    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      instr     <= NOP;
      old_pc    <= '0;
      read_data <= '0;
      fault     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            if (req_misaligned) begin
              fault <= 1'b1;
              state <= ST_DONE;
            end else begin
              kind      <= req_kind;
              mem_addr  <= req_addr;
              mem_wdata <= write_data;
              cap_pc    <= pc;
              state     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            case (kind)
              KIND_FETCH: begin
                instr  <= mem_rdata;
                old_pc <= cap_pc;
              end
              KIND_LOAD: read_data <= mem_rdata;
              default: ;
            endcase
            state <= ST_DONE;
          end else if (timeout) begin
            fault <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from state, so an async reset drops them at once.
  assign mem_req = (state == ST_ACCESS);
  assign mem_we  = (state == ST_ACCESS) && (kind == KIND_STORE);
  assign busy    = (state == ST_ACCESS);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level expectation model
// plus directed vectors with literal expectations.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ir_write, address_source, memory_write;
  logic [31:0] pc, alu_result, write_data;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] instr, old_pc, read_data;
  logic        busy, done, fault;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
    .clock(clock), .reset(reset),
    .ir_write(ir_write), .address_source(address_source), .memory_write(memory_write),
    .pc(pc), .alu_result(alu_result), .write_data(write_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr(instr), .old_pc(old_pc), .read_data(read_data),
    .busy(busy), .done(done), .fault(fault)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Expected DUT outputs for the current cycle
  logic        exp_req, exp_we, exp_busy, exp_done, exp_fault;
  logic [31:0] exp_addr, exp_wdata, exp_instr, exp_old_pc, exp_read_data;
  bit          chk_en = 1'b0;
  int          busy_seen, req_seen;

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("mem_req", mem_req, exp_req);
      check("fault", fault, exp_fault);
      check("instr", instr, exp_instr);
      check("old_pc", old_pc, exp_old_pc);
      check("read_data", read_data, exp_read_data);
      if (exp_req) begin
        check("mem_addr", mem_addr, exp_addr);
        check("mem_we", mem_we, exp_we);
        check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (busy) busy_seen++;
      if (mem_req) req_seen++;
    end
  end

  task automatic drop_requests();
    ir_write = 1'b0; address_source = 1'b0; memory_write = 1'b0;
  endtask

  task automatic set_idle_exp();
    exp_req = 1'b0; exp_we = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
  endtask

  // One controller transaction starting at the current cycle (called #1 after a posedge).
  // wait_n: mem_ready cycles withheld; hold: keep the request high through the done cycle.
  task automatic txn(input logic ir, input logic as_, input logic mw,
                     input logic [31:0] pc_v, input logic [31:0] alu_v,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int wait_n, input bit hold);
    logic [31:0] a;
    bit store, mis;
    store = !ir && mw;
    a     = ir ? pc_v : alu_v;
    mis   = (a[1:0] != 2'b00);
    ir_write = ir; address_source = as_; memory_write = mw;
    pc = pc_v; alu_result = alu_v; write_data = wd;
    set_idle_exp();
    @(posedge clock); #1;
    if (!hold) drop_requests();
    if (mis) begin
      exp_fault = 1'b1;
      exp_done  = 1'b1;
    end else begin
      exp_req = 1'b1; exp_busy = 1'b1; exp_addr = a; exp_we = store; exp_wdata = wd;
      mem_rdata = rd;
      for (int i = 0; i <= wait_n; i++) begin
        mem_ready = (i == wait_n);
        @(posedge clock); #1;
      end
      mem_ready = 1'b0;
      set_idle_exp();
      exp_done = 1'b1;
      if (ir) begin
        exp_instr  = rd;
        exp_old_pc = pc_v;
      end else if (!store) begin
        exp_read_data = rd;
      end
    end
    @(posedge clock); #1;
    drop_requests();
    exp_done = 1'b0;
  endtask

  task automatic model_reset();
    set_idle_exp();
    exp_fault = 1'b0; exp_instr = 32'h0000_0013; exp_old_pc = '0; exp_read_data = '0;
    exp_addr = '0; exp_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drop_requests();
    pc = '0; alu_result = '0; write_data = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_old_pc", old_pc, 32'h0);
    check("rst_read_data", read_data, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clock); #1;

    // 1: fetch, zero wait
    busy_seen = 0;
    txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0050_0093, 0, 1'b0);
    check("t1_busy_cycles", busy_seen, 1);
    check("t1_instr", instr, 32'h0050_0093);
    check("t1_old_pc", old_pc, 32'h10);

    // 2: load, three wait cycles
    busy_seen = 0;
    txn(1'b0, 1'b1, 1'b0, 32'h14, 32'h84, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    check("t2_busy_cycles", busy_seen, 4);
    check("t2_read_data", read_data, 32'hDEAD_BEEF);
    check("t2_instr", instr, 32'h0050_0093);

    // 3: store, one wait cycle
    txn(1'b0, 1'b1, 1'b1, 32'h18, 32'h40, 32'h1234, 32'hCAFE_F00D, 1, 1'b0);
    check("t3_read_data", read_data, 32'hDEAD_BEEF);
    check("t3_instr", instr, 32'h0050_0093);

    // 4: fetch and data request together; fetch wins
    txn(1'b1, 1'b1, 1'b0, 32'h20, 32'h80, 32'h0, 32'h00A0_0113, 0, 1'b0);
    check("t4_old_pc", old_pc, 32'h20);
    check("t4_instr", instr, 32'h00A0_0113);
    check("t4_read_data", read_data, 32'hDEAD_BEEF);

    // Request held through DONE must not start a second access
    busy_seen = 0;
    txn(1'b1, 1'b0, 1'b0, 32'h24, 32'h0, 32'h0, 32'h0000_0533, 2, 1'b1);
    check("hold_busy_cycles", busy_seen, 3);
    check("hold_instr", instr, 32'h0000_0533);

    // 5: misaligned load
    busy_seen = 0; req_seen = 0;
    txn(1'b0, 1'b1, 1'b0, 32'h28, 32'h42, 32'h0, 32'h5555_5555, 0, 1'b0);
    check("t5_req_cycles", req_seen, 0);
    check("t5_fault", fault, 1'b1);
    check("t5_read_data", read_data, 32'hDEAD_BEEF);

    // fault is sticky across a later good access
    txn(1'b0, 1'b1, 1'b0, 32'h2C, 32'h88, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
    check("sticky_fault", fault, 1'b1);
    check("sticky_read_data", read_data, 32'h0BAD_F00D);

    // 6: reset in the middle of ACCESS
    chk_en = 1'b0;
    ir_write = 1'b1; pc = 32'h30;
    @(posedge clock); #1;
    drop_requests();
    mem_ready = 1'b0;
    @(negedge clock);
    check("t6_req_before_reset", mem_req, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_instr", instr, 32'h0000_0013);
    check("t6_read_data", read_data, 32'h0);
    check("t6_fault", fault, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    @(posedge clock); #1;
    txn(1'b1, 1'b0, 1'b0, 32'h34, 32'h0, 32'h0, 32'h0010_0073, 1, 1'b0);
    check("recover_instr", instr, 32'h0010_0073);

`ifdef MEM_TIMEOUT_EN
    begin
      int cnt;
      chk_en = 1'b0;
      cnt = 0;
      ir_write = 1'b1; pc = 32'h40;
      @(posedge clock); #1;
      drop_requests();
      mem_ready = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
        @(negedge clock);
        if (busy) cnt++;
      end
      check("to_busy_cycles", cnt, 255);
      check("to_done", done, 1'b1);
      check("to_fault", fault, 1'b1);
      check("to_instr", instr, 32'h0010_0073);
      @(posedge clock); #1;
    end
`endif

    chk_en = 1'b0;
    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
